// File: rtl/bit_serial_mult_fx_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the width of the per-product bit counter.
package bit_serial_mult_fx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Counter must hold 0..w-1.
   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/bit_serial_mult_fx_saturate.sv
// Combinational fixed-point output stage: shift the full product right by
// SHIFT (arithmetic when SIGNED, i.e. truncation toward -inf) and clamp it
// into an OUT_W-bit range, flagging when clamping altered the value.
module fx_saturate
   import bit_serial_mult_fx_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 0,
   parameter int SIGNED = 1
) (
   input  logic [IN_W-1:0]  acc,
   output logic [OUT_W-1:0] fx,
   output logic             clamped
);

   function automatic logic [IN_W-1:0] rescale(input logic [IN_W-1:0] v);
      logic signed [IN_W-1:0] sv;
      sv = $signed(v);
      if (SIGNED != 0) return $unsigned(sv >>> SHIFT);
      return v >> SHIFT;
   endfunction

   // Returns {clamped, value}.
   function automatic logic [OUT_W:0] saturate(input logic [IN_W-1:0] v);
      if (SIGNED != 0) begin
         if ((&v[IN_W-1:OUT_W-1]) || !(|v[IN_W-1:OUT_W-1]))
            return {1'b0, v[OUT_W-1:0]};
         else if (v[IN_W-1])
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
         else
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end
      if (!(|v[IN_W-1:OUT_W]))
         return {1'b0, v[OUT_W-1:0]};
      return {1'b1, {OUT_W{1'b1}}};
   endfunction

   logic [IN_W-1:0] shifted;

   // Rescale then clamp the finished product.
   always_comb begin
      shifted        = rescale(acc);
      {clamped, fx}  = saturate(shifted);
   end

endmodule

// File: rtl/bit_serial_mult_fx.sv
// Shift-add bit-serial multiplier: one multiplier bit per clock, exact
// 2*WIDTH product plus a rescaled, saturated WIDTH-bit fixed-point value.
// A new start is accepted while idle or in the final bit cycle, giving one
// product every WIDTH cycles when start is held.
module bit_serial_mult_fx
   import bit_serial_mult_fx_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FRAC   = 0,
   parameter int SIGNED = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   output logic               busy,
   output logic               finished,
   output logic [2*WIDTH-1:0] out,
   output logic [WIDTH-1:0]   out_fx,
   output logic               overflow
);

   localparam int CW = cnt_w(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t                 state;
   logic [CW-1:0]          count;
   logic [WIDTH-1:0]       y_sr;
   logic signed [PW-1:0]   x_sh;
   logic signed [PW-1:0]   acc;
   logic signed [PW-1:0]   addend;
   logic signed [PW-1:0]   acc_nxt;
   logic signed [PW-1:0]   x_ext;
   logic                   last;
   logic                   accept;
   logic [WIDTH-1:0]       fx_w;
   logic                   fx_ovf;

   assign busy   = (state == ST_RUN);
   assign last   = (state == ST_RUN) && (count == CW'(WIDTH - 1));
   assign accept = start && ((state == ST_IDLE) || last);
   assign x_ext  = (SIGNED != 0) ? $signed({{WIDTH{in_x[WIDTH-1]}}, in_x})
                                 : $signed({{WIDTH{1'b0}}, in_x});

   // Partial-product step; the MSB carries negative weight in signed mode.
   always_comb begin
      addend = '0;
      if (y_sr[0])
         addend = (last && (SIGNED != 0)) ? -x_sh : x_sh;
      acc_nxt = acc + addend;
   end

   fx_saturate #(
      .IN_W   (PW),
      .OUT_W  (WIDTH),
      .SHIFT  (FRAC),
      .SIGNED (SIGNED)
   ) u_sat (
      .acc     (acc_nxt),
      .fx      (fx_w),
      .clamped (fx_ovf)
   );

   // Control FSM, bit counter and held result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         finished <= 1'b0;
         out      <= '0;
         out_fx   <= '0;
         overflow <= 1'b0;
      end else begin
         finished <= last;
         if (last) begin
            out      <= acc_nxt;
            out_fx   <= fx_w;
            overflow <= fx_ovf;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  count <= '0;
               end
            end
            ST_RUN: begin
               if (last) begin
                  state <= start ? ST_RUN : ST_IDLE;
                  count <= '0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand shift registers and accumulator; capture on accept, shift in RUN.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_sh <= x_ext;
         y_sr <= in_y;
         acc  <= '0;
      end else if (state == ST_RUN) begin
         x_sh <= x_sh <<< 1;
         y_sr <= y_sr >> 1;
         acc  <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_bit_serial_mult_fx.sv
// Bench for bit_serial_mult_fx: twelve configurations (WIDTH 4/8/12,
// signed/unsigned, FRAC 0 or WIDTH/2) run directed corner operands,
// protocol scenarios and random products against a plain-arithmetic model.
module tb_bit_serial_mult_fx;

   localparam int NCFG = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec     = 0;
   int n_miscmp  = 0;
   int n_done    = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int W = 4 + 4 * (g / 4);
      localparam int S = (g / 2) % 2;
      localparam int F = (g % 2) * (W / 2);

      logic             rst_n;
      logic             start;
      logic [W-1:0]     in_x;
      logic [W-1:0]     in_y;
      logic             busy;
      logic             finished;
      logic [2*W-1:0]   out;
      logic [W-1:0]     out_fx;
      logic             overflow;

      bit_serial_mult_fx #(.WIDTH(W), .FRAC(F), .SIGNED(S)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (start),
         .in_x     (in_x),
         .in_y     (in_y),
         .busy     (busy),
         .finished (finished),
         .out      (out),
         .out_fx   (out_fx),
         .overflow (overflow)
      );

      function automatic string tg(input string s);
         return $sformatf("W%0d_S%0d_F%0d_%s", W, S, F, s);
      endfunction

      // Reference: integer product, then floor-divide by 2^F and clamp.
      function automatic void model(input longint x, input longint y,
                                    output longint p, output longint fx,
                                    output longint ov);
         longint sx, sy, full, sh, lo, hi, cl;
         sx = x;
         sy = y;
         if (S != 0 && x >= (longint'(1) << (W - 1))) sx = x - (longint'(1) << W);
         if (S != 0 && y >= (longint'(1) << (W - 1))) sy = y - (longint'(1) << W);
         full = sx * sy;
         p    = full & ((longint'(1) << (2 * W)) - 1);
         sh   = full >>> F;
         lo   = (S != 0) ? -(longint'(1) << (W - 1)) : 0;
         hi   = (S != 0) ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
         cl   = (sh > hi) ? hi : (sh < lo) ? lo : sh;
         ov   = (cl != sh) ? 1 : 0;
         fx   = cl & ((longint'(1) << W) - 1);
      endfunction

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic do_mult(input longint x, input longint y);
         longint ep, ef, eo;
         logic [2*W-1:0] prev;
         int lat;
         bit held;
         model(x, y, ep, ef, eo);
         prev = out;
         lat  = 0;
         held = 1'b1;
         in_x  = W'(x);
         in_y  = W'(y);
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int k = 1; k <= W + 2; k++) begin
            tick();
            if (finished) begin
               lat = k;
               break;
            end
            if (out !== prev) held = 1'b0;
         end
         check_val(tg("latency"), lat, W);
         check_val(tg("out_held"), held, 1);
         check_val(tg("busy_at_fin"), busy, 0);
         check_val(tg("out"), out, ep);
         check_val(tg("out_fx"), out_fx, ef);
         check_val(tg("overflow"), overflow, eo);
         tick();
         check_val(tg("fin_one_cycle"), finished, 0);
      endtask

      initial begin
         longint mn, al, mx;
         longint ep, ef, eo;
         longint px[4], py[4], bp[4], bf[4], bo[4];
         int lat;
         bit bad;

         mn = longint'(1) << (W - 1);
         al = (longint'(1) << W) - 1;
         mx = mn - 1;

         rst_n = 1'b0;
         start = 1'b0;
         in_x  = '0;
         in_y  = '0;
         tick();
         tick();
         check_val(tg("rst_busy"), busy, 0);
         check_val(tg("rst_fin"), finished, 0);
         check_val(tg("rst_out"), out, 0);
         check_val(tg("rst_fx"), out_fx, 0);
         check_val(tg("rst_ovf"), overflow, 0);
         rst_n = 1'b1;
         tick();

         // Corner operands.
         do_mult(7, al - 2);
         do_mult(mn, mn);
         do_mult(al, al);
         do_mult(mx, mx);
         do_mult(mn, mx);
         do_mult(0, mx);
         do_mult(mx, 0);
         do_mult(1, 1);
         do_mult(3 << (W / 2 - 1), 2 << (W / 2));

         // start re-pulsed mid-product is ignored.
         model(5, al, ep, ef, eo);
         in_x  = W'(5);
         in_y  = W'(al);
         start = 1'b1;
         tick();
         start = 1'b0;
         lat   = 0;
         for (int k = 1; k <= W + 2; k++) begin
            tick();
            if (k == 2) begin
               start = 1'b1;
               in_x  = W'(mx);
               in_y  = W'(3);
            end else begin
               start = 1'b0;
            end
            if (finished) begin
               lat = k;
               break;
            end
         end
         start = 1'b0;
         check_val(tg("ign_latency"), lat, W);
         check_val(tg("ign_out"), out, ep);
         bad = 1'b0;
         for (int k = 0; k < W + 2; k++) begin
            tick();
            if (finished || busy) bad = 1'b1;
         end
         check_val(tg("ign_no_second"), bad, 0);

         // start held high: one product every W cycles.
         for (int k = 0; k < 4; k++) begin
            px[k] = $urandom_range(0, int'(al));
            py[k] = $urandom_range(0, int'(al));
            model(px[k], py[k], bp[k], bf[k], bo[k]);
         end
         in_x  = W'(px[0]);
         in_y  = W'(py[0]);
         start = 1'b1;
         tick();
         bad = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
               in_x = W'(px[k]);
               in_y = W'(py[k]);
            end else begin
               start = 1'b0;
            end
            for (int j = 1; j <= W; j++) begin
               tick();
               if (j < W) begin
                  if (finished) bad = 1'b1;
               end else begin
                  check_val(tg("b2b_fin"), finished, 1);
                  check_val(tg("b2b_out"), out, bp[k-1]);
                  check_val(tg("b2b_fx"), out_fx, bf[k-1]);
                  check_val(tg("b2b_ovf"), overflow, bo[k-1]);
                  check_val(tg("b2b_busy"), busy, (k < 4) ? 1 : 0);
               end
            end
         end
         check_val(tg("b2b_no_early_fin"), bad, 0);
         tick();

         // Reset mid-product discards the partial result.
         in_x  = W'(mx);
         in_y  = W'(mx);
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (3) tick();
         rst_n = 1'b0;
         tick();
         check_val(tg("mrst_busy"), busy, 0);
         check_val(tg("mrst_fin"), finished, 0);
         check_val(tg("mrst_out"), out, 0);
         check_val(tg("mrst_fx"), out_fx, 0);
         check_val(tg("mrst_ovf"), overflow, 0);
         rst_n = 1'b1;
         bad = 1'b0;
         for (int k = 0; k < W + 2; k++) begin
            tick();
            if (finished) bad = 1'b1;
         end
         check_val(tg("mrst_no_fin"), bad, 0);
         do_mult(mx, 3);

         // Random regression.
         for (int n = 0; n < 30; n++)
            do_mult($urandom_range(0, int'(al)), $urandom_range(0, int'(al)));

         n_done++;
      end
   end

   initial begin
      for (int c = 0; c < 60000 && n_done < NCFG; c++)
         @(posedge clk);
      if (n_done < NCFG)
         check_val("completion_timeout", n_done, NCFG);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
